// File: rtl/sdf_stage_ctrl_if.sv
// Handshake and control bundle between an SDF butterfly stage datapath
// and its controller: sample strobes in, mux selects and framing out.
interface sdf_stage_ctrl_if #(
    parameter int ADDR_W = 3
) ();
    logic              in_valid;
    logic              in_start;
    logic              bf_sel;
    logic              out_sel;
    logic              out_valid;
    logic              out_start;
    logic              out_last;
    logic [ADDR_W-1:0] tw_addr;
    logic              frame_err;
    logic              busy;

    modport master (
        output in_valid,
        output in_start,
        input  bf_sel,
        input  out_sel,
        input  out_valid,
        input  out_start,
        input  out_last,
        input  tw_addr,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_start,
        output bf_sel,
        output out_sel,
        output out_valid,
        output out_start,
        output out_last,
        output tw_addr,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/sdf_stage_ctrl.sv
// Controller for one single-path delay-feedback FFT stage: sequences the
// fill / butterfly phases of each frame and drains the delay line through the twiddle multiplier.
module sdf_stage_ctrl #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    sdf_stage_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        BFLY = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DCNT_FULL = (ADDR_W + 1)'(DEPTH);

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]   cnt_d;
    logic [ADDR_W:0]     dcnt_q;
    logic [ADDR_W:0]     dcnt_d;
    logic                err_q;
    logic                err_d;
    logic                load_drain;
    logic                draining;
    logic                cnt_last;
    logic                take;
    logic                restart;
    logic                gap;

    assign draining = (dcnt_q != '0);
    assign cnt_last = (cnt_q == CNT_LAST);
    assign take     = bus.in_valid & ~bus.in_start;
    assign restart  = bus.in_valid & bus.in_start;
    assign gap      = ~bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            err_q   <= err_d;
        end
    end

    // An in_start inside a frame is both an error and the first sample
    // of the next frame, so it re-enters FILL rather than dropping to IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        load_drain = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (restart) begin
                    state_d = FILL;
                    cnt_d   = ADDR_W'(1);
                end
            end
            FILL: begin
                unique case (1'b1)
                    gap: begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                    restart: begin
                        err_d   = 1'b1;
                        state_d = FILL;
                        cnt_d   = ADDR_W'(1);
                    end
                    (take & cnt_last): begin
                        state_d = BFLY;
                        cnt_d   = '0;
                    end
                    (take & ~cnt_last): begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                    end
                    default: ;
                endcase
            end
            BFLY: begin
                unique case (1'b1)
                    gap: begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                    restart: begin
                        err_d   = 1'b1;
                        state_d = FILL;
                        cnt_d   = ADDR_W'(1);
                    end
                    (take & cnt_last): begin
                        // IDLE accepts a start on the very next cycle,
                        // which gives a seamless back-to-back frame.
                        state_d    = IDLE;
                        cnt_d      = '0;
                        load_drain = 1'b1;
                    end
                    (take & ~cnt_last): begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                    end
                    default: ;
                endcase
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        dcnt_d = dcnt_q;
        if (load_drain) begin
            dcnt_d = DCNT_FULL;
        end else if (draining) begin
            dcnt_d = dcnt_q - (ADDR_W + 1)'(1);
        end
    end

    // Output decode is gated by rst so the datapath sees a quiet stage
    // for the whole reset cycle, not only after the edge.
    always_comb begin
        bus.bf_sel    = 1'b0;
        bus.out_sel   = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_start = 1'b0;
        bus.out_last  = 1'b0;
        bus.tw_addr   = '0;
        bus.frame_err = 1'b0;
        bus.busy      = 1'b0;
        if (!rst) begin
            bus.frame_err = err_q;
            bus.busy      = (state_q != IDLE) | draining;
            if (state_q == BFLY) begin
                bus.bf_sel    = 1'b1;
                bus.out_valid = bus.in_valid;
                bus.out_start = bus.in_valid & (cnt_q == '0);
            end
            if (draining) begin
                bus.out_sel   = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_last  = (dcnt_q == (ADDR_W + 1)'(1));
                bus.tw_addr   = ADDR_W'(DCNT_FULL - dcnt_q);
            end
        end
    end

endmodule
